// File: rtl/display_defs_pkg.sv
// -----------------------------------------------------------------------------
// display_defs_pkg
// Shared definitions for the result display driver: conversion FSM states,
// fixed segment patterns, display geometry and the double-dabble nibble
// adjustment step.
// -----------------------------------------------------------------------------
package display_defs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK  = 7'h00;
    localparam logic [6:0] SEG_MINUS  = 7'h40;
    localparam logic [6:0] SEG_DIGIT0 = 7'h3F;

    localparam int NUM_POS = 6;
    localparam int NUM_DIG = 5;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 so that the
    // following left shift carries correctly into the next decade.
    function automatic logic [4*NUM_DIG-1:0] dabble_adjust(input logic [4*NUM_DIG-1:0] w);
        logic [4*NUM_DIG-1:0] r;
        r = w;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (w[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to 7-segment pattern, active-high, {g,f,e,d,c,b,a}.
// Ports:
//   digit_i  in  4  BCD digit 0-9 (codes 10-15 decode to blank)
//   blank_i  in  1  force the position dark (leading-zero suppression)
//   seg_o    out 7  segment pattern
// -----------------------------------------------------------------------------
module seg7_decode
    import display_defs_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_DIGIT0;
                4'd1:    seg_o = 7'h06;
                4'd2:    seg_o = 7'h5B;
                4'd3:    seg_o = 7'h4F;
                4'd4:    seg_o = 7'h66;
                4'd5:    seg_o = 7'h6D;
                4'd6:    seg_o = 7'h7D;
                4'd7:    seg_o = 7'h07;
                4'd8:    seg_o = 7'h7F;
                4'd9:    seg_o = 7'h6F;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display_driver.sv
// -----------------------------------------------------------------------------
// result_display_driver
// Captures a signed 16-bit calculator result on `load`, converts its magnitude
// to 5 BCD digits with a sequential double-dabble (16 shift cycles), and scans
// sign + digits onto a 6-position multiplexed 7-segment display with leading
// zeros blanked.
// Ports:
//   clk       in   1   system clock
//   nRST      in   1   synchronous active-low reset
//   load      in   1   strobe: sample value_in (ignored while busy)
//   value_in  in  16   signed result
//   busy      out  1   conversion in progress (SHIFT/DONE states)
//   done      out  1   one-cycle pulse when bcd/neg update
//   neg       out  1   sign of last converted value (0 for zero)
//   bcd       out 20   {d4,d3,d2,d1,d0}, d0 = ones
//   seg       out  7   {g,f,e,d,c,b,a} for the enabled position
//   an        out  6   one-hot position enable, an[5] = sign position
// -----------------------------------------------------------------------------
module result_display_driver
    import display_defs_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter bit SEG_ACT_LO = 1'b0
)(
    input  logic               clk,
    input  logic               nRST,
    input  logic               load,
    input  logic signed [15:0] value_in,
    output logic               busy,
    output logic               done,
    output logic               neg,
    output logic [19:0]        bcd,
    output logic [6:0]         seg,
    output logic [5:0]         an
);

    localparam int          PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0]  SEG_INV  = {7{SEG_ACT_LO}};
    localparam logic [5:0]  AN_INV   = {6{SEG_ACT_LO}};

    conv_state_t state_q, state_d;
    logic [15:0] mag_q,  mag_d;
    logic [19:0] work_q, work_d;
    logic [3:0]  cnt_q,  cnt_d;
    logic        sign_q, sign_d;
    logic [19:0] bcd_q,  bcd_d;
    logic        neg_q,  neg_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       pos_q, pos_d;
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       an_q,  an_d;

    logic [15:0] mag_in;
    logic [19:0] work_adj;
    logic [3:0]  digit_sel;
    logic        blank_sel;
    logic [NUM_DIG-1:0] blank;
    logic [6:0]  dec_seg;

    // |value_in| as unsigned; -32768 maps to 16'h8000 without overflow.
    assign mag_in   = value_in[15] ? 16'(-value_in) : 16'(value_in);
    assign work_adj = dabble_adjust(work_q);

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            pre_q   <= '0;
            pos_q   <= '0;
            seg_q   <= SEG_DIGIT0 ^ SEG_INV;
            an_q    <= 6'b000001 ^ AN_INV;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
            pos_q   <= pos_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    // Working datapath is always loaded before use, so it carries no reset.
    always_ff @(posedge clk) begin
        mag_q  <= mag_d;
        work_q <= work_d;
        sign_q <= sign_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (cnt_q == 4'd15) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mag_d  = mag_q;
        work_d = work_q;
        cnt_d  = cnt_q;
        sign_d = sign_q;
        bcd_d  = bcd_q;
        neg_d  = neg_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    mag_d  = mag_in;
                    sign_d = value_in[15];
                    work_d = '0;
                    cnt_d  = '0;
                end
            end
            SHIFT: begin
                {work_d, mag_d} = {work_adj, mag_q} << 1;
                cnt_d = cnt_q + 4'd1;
            end
            DONE: begin
                bcd_d  = work_q;
                // A zero magnitude yields all-zero BCD; never show "-0".
                neg_d  = sign_q && (work_q != '0);
                done_d = 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Scan prescaler and position index.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        pos_d = pos_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            pos_d = (pos_q == 3'(NUM_POS - 1)) ? 3'd0 : pos_q + 3'd1;
        end
    end

    // Digit k is dark when it and every higher digit are zero; d0 always lit.
    always_comb begin
        blank = '0;
        blank[NUM_DIG-1] = (bcd_q[4*NUM_DIG-1 -: 4] == 4'd0);
        for (int k = NUM_DIG - 2; k >= 1; k--) begin
            blank[k] = blank[k+1] && (bcd_q[k*4 +: 4] == 4'd0);
        end
        blank[0] = 1'b0;
    end

    always_comb begin
        digit_sel = 4'd0;
        blank_sel = 1'b1;
        case (pos_q)
            3'd0: begin digit_sel = bcd_q[3:0];   blank_sel = blank[0]; end
            3'd1: begin digit_sel = bcd_q[7:4];   blank_sel = blank[1]; end
            3'd2: begin digit_sel = bcd_q[11:8];  blank_sel = blank[2]; end
            3'd3: begin digit_sel = bcd_q[15:12]; blank_sel = blank[3]; end
            3'd4: begin digit_sel = bcd_q[19:16]; blank_sel = blank[4]; end
            default: ;
        endcase
    end

    seg7_decode u_dec (
        .digit_i (digit_sel),
        .blank_i (blank_sel),
        .seg_o   (dec_seg)
    );

    always_comb begin
        if (pos_q == 3'(NUM_POS - 1)) begin
            seg_d = (neg_q ? SEG_MINUS : SEG_BLANK) ^ SEG_INV;
        end else begin
            seg_d = dec_seg ^ SEG_INV;
        end
        an_d = (6'b000001 << pos_q) ^ AN_INV;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign neg  = neg_q;
    assign bcd  = bcd_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_result_display_driver.sv
// -----------------------------------------------------------------------------
// tb_result_display_driver
// Directed bench for result_display_driver with SCAN_DIV=4, active-high
// outputs. Expected digits and segment patterns are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_result_display_driver;

    logic               clk = 1'b0;
    logic               nRST = 1'b0;
    logic               load = 1'b0;
    logic signed [15:0] value_in = '0;
    logic               busy, done, neg;
    logic [19:0]        bcd;
    logic [6:0]         seg;
    logic [5:0]         an;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
    localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S8 = 7'h7F;
    localparam logic [6:0] SB = 7'h00, SM = 7'h40;

    result_display_driver #(.SCAN_DIV(4), .SEG_ACT_LO(1'b0)) dut (
        .clk      (clk),
        .nRST     (nRST),
        .load     (load),
        .value_in (value_in),
        .busy     (busy),
        .done     (done),
        .neg      (neg),
        .bcd      (bcd),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load a value and follow the conversion edge by edge.
    task automatic run_conv(input string tag, input logic signed [15:0] v,
                            input logic [19:0] exp_bcd, input logic exp_neg);
        int early_done;
        int busy_hi;
        value_in = v;
        load     = 1'b1;
        tick();                       // E0
        load     = 1'b0;
        value_in = '0;
        early_done = 0;
        busy_hi    = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();                   // E1..E16
            if (done === 1'b1) early_done++;
            if (busy === 1'b1) busy_hi++;
        end
        chk({tag, "_early_done"}, early_done, 0);
        chk({tag, "_busy_cycles"}, busy_hi, 16);
        tick();                       // E17
        chk({tag, "_done"}, done, 1);
        chk({tag, "_bcd"}, bcd, exp_bcd);
        chk({tag, "_neg"}, neg, exp_neg);
        chk({tag, "_busy_after"}, busy, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    // Watch one full 24-cycle scan period and check order, dwell and patterns.
    task automatic check_display(input string tag,
                                 input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                                 input logic [6:0] e3, input logic [6:0] e4, input logic [6:0] e5);
        logic [6:0] exp_seg [6];
        int dwell [6];
        int bad_hot, bad_seg, bad_order, bad_dwell, prev, p;
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2;
        exp_seg[3] = e3; exp_seg[4] = e4; exp_seg[5] = e5;
        for (int k = 0; k < 6; k++) dwell[k] = 0;
        bad_hot = 0; bad_seg = 0; bad_order = 0; bad_dwell = 0; prev = -1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (!$onehot(an)) begin
                bad_hot++;
            end else begin
                p = 0;
                for (int k = 0; k < 6; k++) if (an[k]) p = k;
                dwell[p]++;
                if (seg !== exp_seg[p]) bad_seg++;
                if (prev >= 0 && p != prev && p != (prev + 1) % 6) bad_order++;
                prev = p;
            end
        end
        for (int k = 0; k < 6; k++) if (dwell[k] != 4) bad_dwell++;
        chk({tag, "_an_onehot"}, bad_hot, 0);
        chk({tag, "_seg"}, bad_seg, 0);
        chk({tag, "_an_order"}, bad_order, 0);
        chk({tag, "_dwell"}, bad_dwell, 0);
    endtask

    initial begin
        int dones;
        int busy_lo;

        // Reset state
        nRST = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_neg", neg, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_an", an, 6'b000001);
        chk("rst_seg", seg, S0);
        nRST = 1'b1;
        check_display("rst_disp", S0, SB, SB, SB, SB, SB);

        // 1: 12345
        run_conv("v12345", 16'sd12345, 20'h12345, 1'b0);
        check_display("v12345_disp", S5, S4, S3, S2, S1, SB);

        // 2: -1
        run_conv("vm1", -16'sd1, 20'h00001, 1'b1);
        check_display("vm1_disp", S1, SB, SB, SB, SB, SM);

        // Interior zeros stay lit below a nonzero digit
        run_conv("v1002", 16'sd1002, 20'h01002, 1'b0);
        check_display("v1002_disp", S2, S0, S0, S1, SB, SB);

        // 3: extremes
        run_conv("v32767", 16'sd32767, 20'h32767, 1'b0);
        run_conv("vm32768", 16'sh8000, 20'h32768, 1'b1);
        check_display("vm32768_disp", S8, S6, S7, S2, S3, SM);

        // 4: zero after a negative result
        run_conv("v0", 16'sd0, 20'h00000, 1'b0);
        check_display("v0_disp", S0, SB, SB, SB, SB, SB);

        // 5: 99, then 5 while busy -> dropped
        value_in = 16'sd99;
        load     = 1'b1;
        tick();                       // E0
        load     = 1'b0;
        dones    = 0;
        busy_lo  = 0;
        tick();                       // E1
        if (busy !== 1'b1) busy_lo++;
        tick();                       // E2
        if (busy !== 1'b1) busy_lo++;
        value_in = 16'sd5;
        load     = 1'b1;
        tick();                       // E3
        load     = 1'b0;
        value_in = '0;
        if (busy !== 1'b1) busy_lo++;
        for (int i = 4; i <= 16; i++) begin
            tick();
            if (busy !== 1'b1) busy_lo++;
            if (done === 1'b1) dones++;
        end
        chk("busyload_busy", busy_lo, 0);
        chk("busyload_early_done", dones, 0);
        tick();                       // E17
        chk("busyload_done", done, 1);
        chk("busyload_bcd", bcd, 20'h00099);
        dones = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        chk("busyload_extra_done", dones, 0);
        chk("busyload_bcd_hold", bcd, 20'h00099);
        chk("busyload_idle", busy, 0);

        // 6: reset on the 8th shift cycle aborts 1234
        value_in = 16'sd1234;
        load     = 1'b1;
        tick();                       // E0
        load     = 1'b0;
        value_in = '0;
        for (int i = 1; i <= 7; i++) tick();
        chk("abort_bcd_held", bcd, 20'h00099);
        nRST = 1'b0;
        tick();                       // E8 with reset
        nRST = 1'b1;
        chk("abort_bcd", bcd, 0);
        chk("abort_neg", neg, 0);
        chk("abort_busy", busy, 0);
        chk("abort_an", an, 6'b000001);
        chk("abort_seg", seg, S0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_bcd_after", bcd, 0);
        run_conv("v7", 16'sd7, 20'h00007, 1'b0);
        check_display("v7_disp", S7, SB, SB, SB, SB, SB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
